// File: rtl/uc_interrupciones.sv
// Multi-channel interrupt sequencer: edge-detected, maskable, fixed-priority
// channels with nested preemption, driving the control unit's one-cycle entry sequence.
module uc_interrupciones #(
    parameter int NUM_IRQ   = 4,
    parameter int PROF_PILA = 4,
    parameter int VW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int NW        = $clog2(PROF_PILA + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               listo,
    input  logic               reti,
    output logic               irq_activa,
    output logic               push,
    output logic [1:0]         s_interrupcion,
    output logic [VW-1:0]      vector,
    output logic [NUM_IRQ-1:0] ack,
    output logic [NW-1:0]      nivel,
    output logic [NUM_IRQ-1:0] pendiente,
    output logic               estado_dbg_o
);

    typedef enum logic {
        REPOSO  = 1'b0,
        ENTRADA = 1'b1
    } estado_t;

    estado_t            estado_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [VW-1:0]      vector_q;
    logic [NUM_IRQ-1:0] ack_q;
    logic               irq_activa_q;
    logic               push_q;
    logic [1:0]         s_int_q;
    logic [NW-1:0]      nivel_q;
    logic [VW-1:0]      stack_q [PROF_PILA];

    logic               cand_valid;
    logic [VW-1:0]      cand_idx;
    logic [NUM_IRQ-1:0] cand_onehot;
    logic [VW-1:0]      top_idx;
    logic               accept;

    // Lowest enabled pending index wins; scanning downward leaves it last-assigned.
    always_comb begin
        cand_valid  = 1'b0;
        cand_idx    = '0;
        cand_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && mask_q[i]) begin
                cand_valid  = 1'b1;
                cand_idx    = VW'(i);
                cand_onehot = NUM_IRQ'(1) << i;
            end
        end
    end

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < PROF_PILA; i++) begin
            if (NW'(i + 1) == nivel_q) begin
                top_idx = stack_q[i];
            end
        end
    end

    assign accept = (estado_q == REPOSO) && cand_valid && listo &&
                    (nivel_q < NW'(PROF_PILA)) &&
                    ((nivel_q == '0) || (cand_idx < top_idx));

    // Clear of the entered channel is applied first so a coincident new edge survives.
    always_comb begin
        pend_d = pend_q;
        if (estado_q == ENTRADA) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (VW'(i) == vector_q) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
        pend_d = pend_d | (irq & ~irq_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q  <= '0;
            mask_q <= '1;
            pend_q <= '0;
        end else begin
            irq_q  <= irq;
            pend_q <= pend_d;
            if (mask_we) begin
                mask_q <= mask_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= REPOSO;
            vector_q     <= '0;
            ack_q        <= '0;
            irq_activa_q <= 1'b0;
            push_q       <= 1'b0;
            s_int_q      <= 2'b00;
            nivel_q      <= '0;
            for (int i = 0; i < PROF_PILA; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            ack_q        <= '0;
            irq_activa_q <= 1'b0;
            push_q       <= 1'b0;
            s_int_q      <= 2'b00;
            case (estado_q)
                REPOSO: begin
                    if (reti && (nivel_q != '0)) begin
                        nivel_q <= nivel_q - NW'(1);
                    end
                    if (accept) begin
                        estado_q     <= ENTRADA;
                        vector_q     <= cand_idx;
                        ack_q        <= cand_onehot;
                        irq_activa_q <= 1'b1;
                        push_q       <= 1'b1;
                        s_int_q      <= 2'b01;
                    end
                end
                ENTRADA: begin
                    estado_q <= REPOSO;
                    for (int i = 0; i < PROF_PILA; i++) begin
                        if (NW'(i) == nivel_q) begin
                            stack_q[i] <= vector_q;
                        end
                    end
                    nivel_q <= nivel_q + NW'(1);
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign irq_activa     = irq_activa_q;
    assign push           = push_q;
    assign s_interrupcion = s_int_q;
    assign vector         = vector_q;
    assign ack            = ack_q;
    assign nivel          = nivel_q;
    assign pendiente      = pend_q;
    assign estado_dbg_o   = estado_q;

endmodule

// File: tb/tb_uc_interrupciones.sv
// Bench for uc_interrupciones: two instances (depth 4 and depth 2) share stimulus
// and are compared each cycle against a stack-based reference model.
module tb_uc_interrupciones;

    localparam int OW = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       listo;
    logic       reti;

    logic       irq_activa0, push0, dbg0;
    logic [1:0] s_int0, vector0;
    logic [3:0] ack0, pend0;
    logic [2:0] nivel0;

    logic       irq_activa1, push1, dbg1;
    logic [1:0] s_int1, vector1;
    logic [3:0] ack1, pend1;
    logic [1:0] nivel1;

    logic [OW-1:0] obs [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance
    logic [3:0] m_pend  [2];
    logic       m_entry [2];
    int         m_vec   [2];
    int         m_lvl   [2];
    int         m_stk   [2][8];
    int         depth   [2];
    logic [3:0] m_mask;
    logic [3:0] m_irq_prev;

    always #5 clk = ~clk;

    uc_interrupciones #(.NUM_IRQ(4), .PROF_PILA(4)) u_dut0 (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
        .listo(listo), .reti(reti), .irq_activa(irq_activa0), .push(push0),
        .s_interrupcion(s_int0), .vector(vector0), .ack(ack0), .nivel(nivel0),
        .pendiente(pend0), .estado_dbg_o(dbg0)
    );

    uc_interrupciones #(.NUM_IRQ(4), .PROF_PILA(2)) u_dut2 (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
        .listo(listo), .reti(reti), .irq_activa(irq_activa1), .push(push1),
        .s_interrupcion(s_int1), .vector(vector1), .ack(ack1), .nivel(nivel1),
        .pendiente(pend1), .estado_dbg_o(dbg1)
    );

    assign obs[0] = {irq_activa0, push0, s_int0, ack0, vector0, {1'b0, nivel0}, pend0, dbg0};
    assign obs[1] = {irq_activa1, push1, s_int1, ack1, vector1, {2'b00, nivel1}, pend1, dbg1};

    function automatic logic [OW-1:0] exp_bus(int k);
        logic [3:0] ackv;
        logic [1:0] vec2;
        logic [3:0] lvl4;
        ackv = m_entry[k] ? (4'b0001 << m_vec[k]) : 4'b0000;
        vec2 = 2'(m_vec[k]);
        lvl4 = 4'(m_lvl[k]);
        return {m_entry[k], m_entry[k], (m_entry[k] ? 2'b01 : 2'b00), ackv, vec2, lvl4,
                m_pend[k], m_entry[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 4'b0000;
            m_entry[k] = 1'b0;
            m_vec[k]   = 0;
            m_lvl[k]   = 0;
        end
        m_mask     = 4'b1111;
        m_irq_prev = 4'b0000;
    endtask

    // One clock edge of the specified behaviour, using the inputs held across the edge.
    task automatic model_step();
        logic [3:0] edges;
        int         cand;
        logic       take;
        edges = irq & ~m_irq_prev;
        for (int k = 0; k < 2; k++) begin
            cand = -1;
            for (int i = 3; i >= 0; i--) begin
                if (m_pend[k][i] && m_mask[i]) cand = i;
            end
            if (m_entry[k]) begin
                m_stk[k][m_lvl[k]] = m_vec[k];
                m_lvl[k]           = m_lvl[k] + 1;
                m_pend[k][m_vec[k]] = 1'b0;
                m_entry[k]         = 1'b0;
            end else begin
                take = (cand >= 0) && listo && (m_lvl[k] < depth[k]);
                if (take && m_lvl[k] > 0) take = (cand < m_stk[k][m_lvl[k] - 1]);
                if (reti && m_lvl[k] > 0) m_lvl[k] = m_lvl[k] - 1;
                if (take) begin
                    m_entry[k] = 1'b1;
                    m_vec[k]   = cand;
                end
            end
            m_pend[k] = m_pend[k] | edges;
        end
        if (mask_we) m_mask = mask_in;
        m_irq_prev = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        irq     = 4'b0000;
        mask_we = 1'b0;
        mask_in = 4'b0000;
        listo   = 1'b0;
        reti    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got=%h exp=%h", k, obs[k], {OW{1'b0}});
            end
        end
        reset = 1'b1;
        listo = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c < 6; c++) begin
            irq  = (c == 0) ? 4'b0100 : 4'b0000;
            reti = (c == 3);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL single_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 0) begin
                checks++;
                if (pend0 !== 4'b0100) begin
                    errors++;
                    $display("FAIL single_pending got=%b exp=0100", pend0);
                end
            end
            if (c == 1) begin
                checks++;
                if ({irq_activa0, push0, s_int0, vector0, ack0} !== {1'b1, 1'b1, 2'b01, 2'd2, 4'b0100}) begin
                    errors++;
                    $display("FAIL single_entry got=%b exp=%b", {irq_activa0, push0, s_int0, vector0, ack0},
                             {1'b1, 1'b1, 2'b01, 2'd2, 4'b0100});
                end
            end
            if (c == 2) begin
                checks++;
                if ({irq_activa0, nivel0, pend0} !== {1'b0, 3'd1, 4'b0000}) begin
                    errors++;
                    $display("FAIL single_after got=%b exp=%b", {irq_activa0, nivel0, pend0}, {1'b0, 3'd1, 4'b0000});
                end
            end
            if (c == 3) begin
                checks++;
                if (nivel0 !== 3'd0) begin
                    errors++;
                    $display("FAIL single_reti got=%0d exp=0", nivel0);
                end
            end
        end
    endtask

    task automatic test_priority();
        for (int c = 0; c < 11; c++) begin
            irq  = (c == 0) ? 4'b1010 : 4'b0000;
            reti = (c == 6) || (c == 9);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL priority_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 1 || c == 7) begin
                checks++;
                if ({irq_activa0, vector0} !== {1'b1, (c == 1) ? 2'd1 : 2'd3}) begin
                    errors++;
                    $display("FAIL priority_vector c=%0d got=%b exp=%b", c, {irq_activa0, vector0},
                             {1'b1, (c == 1) ? 2'd1 : 2'd3});
                end
            end
            if (c == 5) begin
                checks++;
                if ({irq_activa0, nivel0, pend0} !== {1'b0, 3'd1, 4'b1000}) begin
                    errors++;
                    $display("FAIL priority_wait got=%b exp=%b", {irq_activa0, nivel0, pend0}, {1'b0, 3'd1, 4'b1000});
                end
            end
            if (c == 6) begin
                checks++;
                if (nivel0 !== 3'd0) begin
                    errors++;
                    $display("FAIL priority_reti got=%0d exp=0", nivel0);
                end
            end
        end
    endtask

    task automatic test_nesting();
        for (int c = 0; c < 18; c++) begin
            irq  = (c == 0) ? 4'b0100 : (c == 3) ? 4'b0001 : (c == 6) ? 4'b1000 : 4'b0000;
            reti = (c == 10) || (c == 13) || (c == 16);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL nesting_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 4 || c == 14) begin
                checks++;
                if ({irq_activa0, vector0} !== {1'b1, (c == 4) ? 2'd0 : 2'd3}) begin
                    errors++;
                    $display("FAIL nesting_vector c=%0d got=%b exp=%b", c, {irq_activa0, vector0},
                             {1'b1, (c == 4) ? 2'd0 : 2'd3});
                end
            end
            if (c == 9) begin
                checks++;
                if ({irq_activa0, nivel0, pend0} !== {1'b0, 3'd2, 4'b1000}) begin
                    errors++;
                    $display("FAIL nesting_blocked got=%b exp=%b", {irq_activa0, nivel0, pend0}, {1'b0, 3'd2, 4'b1000});
                end
            end
            if (c == 10 || c == 13) begin
                checks++;
                if (nivel0 !== ((c == 10) ? 3'd1 : 3'd0)) begin
                    errors++;
                    $display("FAIL nesting_reti c=%0d got=%0d exp=%0d", c, nivel0, (c == 10) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_mask();
        for (int c = 0; c < 10; c++) begin
            mask_we = (c == 0) || (c == 5);
            mask_in = (c == 0) ? 4'b1110 : 4'b1111;
            irq     = (c == 1) ? 4'b0001 : 4'b0000;
            reti    = (c == 8);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL mask_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if ({irq_activa0, pend0} !== {1'b0, 4'b0001}) begin
                    errors++;
                    $display("FAIL mask_hold c=%0d got=%b exp=%b", c, {irq_activa0, pend0}, {1'b0, 4'b0001});
                end
            end
            if (c == 6) begin
                checks++;
                if ({irq_activa0, vector0, ack0} !== {1'b1, 2'd0, 4'b0001}) begin
                    errors++;
                    $display("FAIL mask_release got=%b exp=%b", {irq_activa0, vector0, ack0}, {1'b1, 2'd0, 4'b0001});
                end
            end
        end
        mask_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            irq  = (c == 0) ? 4'b1000 : (c == 1) ? 4'b0100 : 4'b0000;
            reti = (c == 5) || (c == 7);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (irq_activa0 !== (c != 2)) begin
                    errors++;
                    $display("FAIL b2b_gap c=%0d got=%b exp=%b", c, irq_activa0, (c != 2));
                end
            end
        end
    endtask

    task automatic test_depth_collision();
        for (int c = 0; c < 45; c++) begin
            irq  = (c == 0 || c == 2) ? 4'b0100 : (c == 4) ? 4'b0010 : (c == 7) ? 4'b0001 : 4'b0000;
            reti = (c >= 12) && (c % 3 == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL depth_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 2) begin
                checks++;
                if ({pend0[2], nivel0} !== {1'b1, 3'd1}) begin
                    errors++;
                    $display("FAIL collision_set got=%b exp=%b", {pend0[2], nivel0}, {1'b1, 3'd1});
                end
            end
            if (c >= 8 && c <= 11) begin
                checks++;
                if ({irq_activa1, nivel1, pend1[0]} !== {1'b0, 2'd2, 1'b1}) begin
                    errors++;
                    $display("FAIL depth_limit c=%0d got=%b exp=%b", c, {irq_activa1, nivel1, pend1[0]}, {1'b0, 2'd2, 1'b1});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            irq     = 4'($urandom) & 4'($urandom);
            listo   = ($urandom_range(0, 3) != 0);
            reti    = ($urandom_range(0, 5) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_in = 4'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL random_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
        end
        irq     = 4'b0000;
        listo   = 1'b1;
        reti    = 1'b0;
        mask_we = 1'b0;
    endtask

    task automatic test_reset_spurious();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            irq  = (c == 1) ? 4'b0100 : 4'b0000;
            reti = (c == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL spurious_model dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
            if (c == 0) begin
                checks++;
                if (nivel0 !== 3'd0) begin
                    errors++;
                    $display("FAIL spurious_reti got=%0d exp=0", nivel0);
                end
            end
            if (c == 2) begin
                checks++;
                if ({irq_activa0, dbg0} !== 2'b11) begin
                    errors++;
                    $display("FAIL reset_setup got=%b exp=11", {irq_activa0, dbg0});
                end
            end
            if (c == 2) break;
        end
        // Asynchronous reset in the middle of the entry cycle
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++;
                $display("FAIL reset_async dut%0d got=%h exp=%h", k, obs[k], {OW{1'b0}});
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_bus(k)) begin
                    errors++;
                    $display("FAIL reset_release dut%0d c=%0d got=%h exp=%h", k, c, obs[k], exp_bus(k));
                end
            end
        end
        checks++;
        if ({irq_activa0, nivel0, dbg0} !== {1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_no_push got=%b exp=%b", {irq_activa0, nivel0, dbg0}, {1'b0, 3'd0, 1'b0});
        end
    endtask

    initial begin
        depth[0] = 4;
        depth[1] = 2;
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_mask();
        test_back_to_back();
        test_depth_collision();
        test_random();
        test_reset_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
